// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: EX forwarding selects, stall/flush control and stall-cycle counter for a 5-stage RV32 pipeline
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int DIV_LAT = 4,
  parameter int PERF_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWEn_mem_i,
  input  logic              RegWEn_wb_i,
  input  logic [31:0]       inst_ex_i,
  input  logic [31:0]       inst_mem_i,
  input  logic [31:0]       inst_wb_i,
  input  logic [1:0]        PC_taken_i,
  input  logic              dmem_ready_i,
  output logic [1:0]        Asel_o,
  output logic [1:0]        Bsel_o,
  output logic              Stall_IF,
  output logic              Stall_ID,
  output logic              Stall_EX,
  output logic              Stall_MEM,
  output logic              Stall_WB,
  output logic              Flush_ID,
  output logic              Flush_EX,
  output logic              Flush_MEM,
  output logic              Flush_WB,
  output logic              div_busy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);
  localparam int CW = DIV_LAT > 2 ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_LAT > 1 ? DIV_LAT - 2 : 0);
  localparam logic DIV_EN = DIV_LAT > 1;
  typedef enum logic {RUN, DIV} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [PERF_W-1:0] r_stall_cnt;
  logic [REG_AW-1:0] w_rs1_ex, w_rs2_ex, w_rd_mem, w_rd_wb;
  logic [1:0] w_asel, w_bsel;
  logic w_mem_hit1, w_mem_hit2, w_wb_hit1, w_wb_hit2;
  logic w_is_load, w_is_store, w_mem_wait, w_lw_stall, w_is_div, w_div_stall, w_redirect, w_stall;
  logic w_unused;
  assign w_rs1_ex   = inst_ex_i[15+:REG_AW];
  assign w_rs2_ex   = inst_ex_i[20+:REG_AW];
  assign w_rd_mem   = inst_mem_i[7+:REG_AW];
  assign w_rd_wb    = inst_wb_i[7+:REG_AW];
  assign w_unused   = ^{inst_ex_i, inst_mem_i, inst_wb_i};
  assign w_mem_hit1 = RegWEn_mem_i && w_rd_mem != '0 && w_rs1_ex == w_rd_mem;
  assign w_mem_hit2 = RegWEn_mem_i && w_rd_mem != '0 && w_rs2_ex == w_rd_mem;
  assign w_wb_hit1  = RegWEn_wb_i && w_rd_wb != '0 && w_rs1_ex == w_rd_wb;
  assign w_wb_hit2  = RegWEn_wb_i && w_rd_wb != '0 && w_rs2_ex == w_rd_wb;
  assign w_asel     = w_mem_hit1 ? 2'b01 : w_wb_hit1 ? 2'b10 : 2'b00;
  assign w_bsel     = w_mem_hit2 ? 2'b01 : w_wb_hit2 ? 2'b10 : 2'b00;
  assign w_is_load  = inst_mem_i[6:0] == 7'b0000011;
  assign w_is_store = inst_mem_i[6:0] == 7'b0100011;
  assign w_mem_wait = ~dmem_ready_i & (w_is_load | w_is_store);
  assign w_lw_stall = w_is_load & (w_mem_hit1 | w_mem_hit2) & ~w_mem_wait;
  assign w_is_div   = inst_ex_i[6:0] == 7'b0110011 && inst_ex_i[31:25] == 7'b0000001 && inst_ex_i[14];
  assign w_div_stall = r_state == RUN ? (w_is_div & DIV_EN & ~w_mem_wait & ~w_lw_stall) : (r_cnt != '0);
  assign w_redirect = (PC_taken_i == 2'b01 || PC_taken_i == 2'b10) & ~w_mem_wait & ~w_lw_stall & ~w_div_stall;
  assign w_stall    = w_mem_wait | w_lw_stall | w_div_stall;
  // Every output is held low while reset is asserted, forwarding selects included.
  assign Asel_o      = rst_i ? 2'b00 : w_asel;
  assign Bsel_o      = rst_i ? 2'b00 : w_bsel;
  assign Stall_IF    = ~rst_i & w_stall;
  assign Stall_ID    = ~rst_i & w_stall;
  assign Stall_EX    = ~rst_i & w_stall;
  assign Stall_MEM   = ~rst_i & w_mem_wait;
  assign Stall_WB    = 1'b0;
  assign Flush_ID    = ~rst_i & w_redirect;
  assign Flush_EX    = ~rst_i & w_redirect;
  assign Flush_MEM   = ~rst_i & (w_lw_stall | w_div_stall) & ~w_mem_wait;
  assign Flush_WB    = ~rst_i & w_mem_wait;
  assign div_busy_o  = ~rst_i & r_state == DIV & r_cnt != '0;
  assign stall_cnt_o = r_stall_cnt;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (r_state == RUN) begin
      if (w_div_stall) begin
        w_state_nxt = DIV;
        w_cnt_nxt   = CNT_INIT;
      end
    end else if (!w_mem_wait) begin
      if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
      else w_state_nxt = RUN;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (Stall_IF && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed checks of forwarding, load-use, divide, memory wait, redirect and reset
module tb_hazard_unit_mc;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        RegWEn_mem_i, RegWEn_wb_i, dmem_ready_i;
  logic [31:0] inst_ex_i, inst_mem_i, inst_wb_i;
  logic [1:0]  PC_taken_i, Asel_o, Bsel_o;
  logic        Stall_IF, Stall_ID, Stall_EX, Stall_MEM, Stall_WB;
  logic        Flush_ID, Flush_EX, Flush_MEM, Flush_WB, div_busy_o;
  logic [31:0] stall_cnt_o;
  int checks = 0, errors = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  hazard_unit_mc #(.REG_AW(5), .DIV_LAT(4), .PERF_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .RegWEn_mem_i(RegWEn_mem_i), .RegWEn_wb_i(RegWEn_wb_i),
    .inst_ex_i(inst_ex_i), .inst_mem_i(inst_mem_i), .inst_wb_i(inst_wb_i),
    .PC_taken_i(PC_taken_i), .dmem_ready_i(dmem_ready_i), .Asel_o(Asel_o), .Bsel_o(Bsel_o),
    .Stall_IF(Stall_IF), .Stall_ID(Stall_ID), .Stall_EX(Stall_EX), .Stall_MEM(Stall_MEM),
    .Stall_WB(Stall_WB), .Flush_ID(Flush_ID), .Flush_EX(Flush_EX), .Flush_MEM(Flush_MEM),
    .Flush_WB(Flush_WB), .div_busy_o(div_busy_o), .stall_cnt_o(stall_cnt_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic quiet;
    RegWEn_mem_i = 0; RegWEn_wb_i = 0; dmem_ready_i = 1; PC_taken_i = 2'b00;
    inst_ex_i = NOP; inst_mem_i = NOP; inst_wb_i = NOP;
  endtask
  task automatic chk_stall(input string tag, input logic s, input logic fm, input logic sm, input logic fw);
    chk({tag, "_stall_if"}, {31'd0, Stall_IF}, {31'd0, s});
    chk({tag, "_stall_id_ex"}, {30'd0, Stall_ID, Stall_EX}, {30'd0, s, s});
    chk({tag, "_flush_mem"}, {31'd0, Flush_MEM}, {31'd0, fm});
    chk({tag, "_stall_mem"}, {31'd0, Stall_MEM}, {31'd0, sm});
    chk({tag, "_flush_wb"}, {31'd0, Flush_WB}, {31'd0, fw});
  endtask
  initial begin
    quiet();
    RegWEn_mem_i = 1; RegWEn_wb_i = 1;
    inst_mem_i = r_type(7'd0, 5'd0, 5'd0, 3'd0, 5'd5);
    inst_wb_i  = r_type(7'd0, 5'd0, 5'd0, 3'd0, 5'd5);
    inst_ex_i  = r_type(7'd0, 5'd5, 5'd5, 3'd0, 5'd1);
    #2;
    chk("rst_asel", {30'd0, Asel_o}, 32'd0);
    chk("rst_bsel", {30'd0, Bsel_o}, 32'd0);
    chk("rst_cnt", stall_cnt_o, 32'd0);
    chk("rst_busy", {31'd0, div_busy_o}, 32'd0);
    #10 rst_i = 0;
    #1;
    chk("fwd_mem_a", {30'd0, Asel_o}, 32'd1);
    chk("fwd_mem_b", {30'd0, Bsel_o}, 32'd1);
    chk_stall("fwd", 0, 0, 0, 0);
    inst_mem_i = r_type(7'd0, 5'd0, 5'd0, 3'd0, 5'd0);
    #1;
    chk("fwd_wb_a", {30'd0, Asel_o}, 32'd2);
    chk("fwd_wb_b", {30'd0, Bsel_o}, 32'd2);
    inst_mem_i = r_type(7'd0, 5'd0, 5'd0, 3'd0, 5'd5);
    inst_ex_i  = r_type(7'd0, 5'd6, 5'd5, 3'd0, 5'd1);
    inst_wb_i  = r_type(7'd0, 5'd0, 5'd0, 3'd0, 5'd6);
    #1;
    chk("fwd_mix_a", {30'd0, Asel_o}, 32'd1);
    chk("fwd_mix_b", {30'd0, Bsel_o}, 32'd2);
    RegWEn_wb_i = 0;
    #1;
    chk("fwd_wb_off_b", {30'd0, Bsel_o}, 32'd0);
    quiet();
    RegWEn_mem_i = 1;
    inst_mem_i = {12'd0, 5'd0, 3'b010, 5'd7, 7'b0000011};
    inst_ex_i  = r_type(7'd0, 5'd0, 5'd7, 3'd0, 5'd8);
    #1;
    chk_stall("lu1", 1, 1, 0, 0);
    tick();
    quiet();
    RegWEn_wb_i = 1;
    inst_wb_i = {12'd0, 5'd0, 3'b010, 5'd7, 7'b0000011};
    inst_ex_i = r_type(7'd0, 5'd0, 5'd7, 3'd0, 5'd8);
    #1;
    chk_stall("lu2", 0, 0, 0, 0);
    chk("lu2_asel", {30'd0, Asel_o}, 32'd2);
    chk("lu2_cnt", stall_cnt_o, 32'd1);
    quiet();
    inst_ex_i = r_type(7'd1, 5'd2, 5'd1, 3'b100, 5'd3);
    #1;
    chk_stall("div1", 1, 1, 0, 0);
    chk("div1_busy", {31'd0, div_busy_o}, 32'd0);
    tick();
    chk_stall("div2", 1, 1, 0, 0);
    chk("div2_busy", {31'd0, div_busy_o}, 32'd1);
    tick();
    chk_stall("div3", 1, 1, 0, 0);
    chk("div3_busy", {31'd0, div_busy_o}, 32'd1);
    tick();
    chk_stall("div4", 0, 0, 0, 0);
    chk("div4_busy", {31'd0, div_busy_o}, 32'd0);
    chk("div4_cnt", stall_cnt_o, 32'd4);
    inst_ex_i = NOP;
    tick();
    inst_ex_i = r_type(7'd1, 5'd2, 5'd1, 3'b110, 5'd3);
    #1;
    chk_stall("mw1", 1, 1, 0, 0);
    tick();
    inst_mem_i = {7'd0, 5'd7, 5'd0, 3'b010, 5'd0, 7'b0100011};
    dmem_ready_i = 0;
    #1;
    chk_stall("mw2", 1, 0, 1, 1);
    chk("mw2_busy", {31'd0, div_busy_o}, 32'd1);
    tick();
    chk_stall("mw3", 1, 0, 1, 1);
    tick();
    dmem_ready_i = 1;
    inst_mem_i = NOP;
    #1;
    chk_stall("mw4", 1, 1, 0, 0);
    chk("mw4_busy", {31'd0, div_busy_o}, 32'd1);
    tick();
    chk_stall("mw5", 1, 1, 0, 0);
    tick();
    chk_stall("mw6", 0, 0, 0, 0);
    chk("mw6_cnt", stall_cnt_o, 32'd9);
    inst_ex_i = NOP;
    tick();
    PC_taken_i = 2'b01;
    #1;
    chk("rd01_flush", {30'd0, Flush_ID, Flush_EX}, 32'd3);
    chk("rd01_stall", {31'd0, Stall_IF}, 32'd0);
    PC_taken_i = 2'b10;
    #1;
    chk("rd10_flush", {30'd0, Flush_ID, Flush_EX}, 32'd3);
    PC_taken_i = 2'b11;
    #1;
    chk("rd11_flush", {30'd0, Flush_ID, Flush_EX}, 32'd0);
    PC_taken_i = 2'b01;
    RegWEn_mem_i = 1;
    inst_mem_i = {12'd0, 5'd0, 3'b010, 5'd7, 7'b0000011};
    inst_ex_i  = r_type(7'd0, 5'd7, 5'd0, 3'd0, 5'd8);
    #1;
    chk("rdlu_flush", {30'd0, Flush_ID, Flush_EX}, 32'd0);
    chk("rdlu_stall", {31'd0, Stall_IF}, 32'd1);
    quiet();
    tick();
    chk("pre_rst_cnt", stall_cnt_o, 32'd9);
    inst_ex_i = r_type(7'd1, 5'd2, 5'd1, 3'b100, 5'd3);
    RegWEn_mem_i = 1;
    inst_mem_i = r_type(7'd0, 5'd0, 5'd0, 3'd0, 5'd1);
    tick();
    chk("rd2_busy", {31'd0, div_busy_o}, 32'd1);
    rst_i = 1;
    #1;
    chk_stall("arst", 0, 0, 0, 0);
    chk("arst_busy", {31'd0, div_busy_o}, 32'd0);
    chk("arst_asel", {30'd0, Asel_o}, 32'd0);
    chk("arst_cnt", stall_cnt_o, 32'd0);
    tick();
    rst_i = 0;
    quiet();
    #1;
    chk_stall("post_rst", 0, 0, 0, 0);
    chk("post_rst_busy", {31'd0, div_busy_o}, 32'd0);
    tick();
    chk("post_rst_stall", {31'd0, Stall_IF}, 32'd0);
    chk("post_rst_cnt", stall_cnt_o, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
